pipelined_custom_adder: RTL
===========================

// Module: pipelined_custom_adder
// PURPOSE
//   Parametrised, pipelined successor of the fixed-width custom adders in the multiplier datapath.
//   - Adds a wide operand A to a narrower operand B, extended to A's width, one carry segment per stage.
//   - B is zero- or sign-extended; the block can add or subtract.
//   - Uses a valid/ready handshake with full back-pressure.
//   - Sits after the partial-product reduction tree, where the final carry-propagate add was the critical path.
// PARAMETERS
//   A_WIDTH    58  width of operand A; the sum is A_WIDTH+1 bits.
//   B_WIDTH    37  width of operand B; must satisfy 1 <= B_WIDTH <= A_WIDTH.
//   SEG_WIDTH  16  carry-chain bits resolved per pipeline stage; 1 <= SEG_WIDTH <= A_WIDTH.
//   SIGNED_B   0   0: zero-extend B to A_WIDTH; 1: sign-extend B from bit B_WIDTH-1.
//   TAG_WIDTH  4   width of the sideband tag carried alongside each operation.
//   Derived: NSEG = ceil(A_WIDTH/SEG_WIDTH); the last segment may be narrower.
// PORTS
//   clk        in   1            clock; all state updates on the rising edge.
//   rst_n      in   1            asynchronous active-low reset.
//   in_valid   in   1            input operation valid.
//   in_ready   out  1            block can accept an operation this cycle.
//   in_a       in   A_WIDTH      operand A, unsigned.
//   in_b       in   B_WIDTH      operand B, extended per SIGNED_B.
//   in_sub     in   1            0: A + ext(B); 1: A - ext(B).
//   in_tag     in   TAG_WIDTH    sideband tag, returned unchanged with the result.
//   out_valid  out  1            result valid.
//   out_ready  in   1            downstream accepts the result.
//   out_sum    out  A_WIDTH+1    {carry_out, sum[A_WIDTH-1:0]}.
//   out_tag    out  TAG_WIDTH    tag of the operation being presented.
// BEHAVIOUR
//   Transfers
//   - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
//   Arithmetic, with bx = ext(B) at A_WIDTH bits
//   - add: out_sum = A + bx, full A_WIDTH+1 bits.
//   - sub: out_sum = A + ~bx + 1. out_sum[A_WIDTH] is carry_out: 1 means no borrow (A >= bx, unsigned).
//   Pipeline
//   - NSEG stages, stage k = 0..NSEG-1.
//   - Stage k adds segment k of A and bx (bx inverted in sub) plus the carry from stage k-1.
//     The carry-in of stage 0 is in_sub.
//   - Each stage registers: valid bit, sum bits resolved so far, carry out, the unprocessed upper
//     A/bx segments, the sub flag and the tag.
//   - The output is the registered last stage. out_sum, out_tag and out_valid come straight from flops.
//   - Latency is NSEG cycles from the input transfer to out_valid; 4 cycles at the defaults.
//   - Throughput is 1 operation per cycle when out_ready=1.
//   Flow control
//   - ready[k] = ~valid[k] | ready[k+1]; ready[NSEG-1] = ~valid[NSEG-1] | out_ready; in_ready = ready[0].
//   - Stage k loads from stage k-1 when ready[k]. Its valid becomes valid[k-1]; stage 0 takes in_valid.
//   - Stalled stages hold all of their contents. out_sum and out_tag are stable while out_valid & ~out_ready.
//   - Order is preserved; there is no loss and no duplication.
//   - Input transfer and output transfer in the same cycle with the pipeline full is legal and does not stall.
//   Reset
//   - rst_n low asynchronously clears every stage register: out_valid=0, out_sum=0, out_tag=0.
//   - in_ready is forced to 0 while rst_n is low.
//   - Operations in flight at reset are discarded.
//   - From the first edge after release, in_ready=1.
//   Edge cases
//   - B_WIDTH == A_WIDTH: no extension.
//   - SEG_WIDTH >= A_WIDTH: NSEG=1, latency 1.
//   - in_* are ignored when in_valid=0; the registered valid stays 0.
// TESTING (default parameters unless stated)
//   1. Full carry ripple: a=58'h3FF_FFFF_FFFF_FFFF, b=1, sub=0 -> out_sum=59'h400_0000_0000_0000, out_valid 4 cycles after accept.
//   2. Streaming: 8 back-to-back ops with tags 0..7, out_ready=1 -> 8 consecutive valid cycles, tags in order, sums match the model.
//   3. Back-pressure: out_ready=0 while streaming -> in_ready falls after 4 accepts; out_sum/out_tag stay stable; releasing yields all ops once, in order.
//   4. Subtract: a=100,b=37,sub=1 -> out_sum=59'h400_0000_0000_003F; a=5,b=7,sub=1 -> out_sum=59'h3FF_FFFF_FFFF_FFFE.
//   5. SIGNED_B=1 instance: a=10, b=37'h1F_FFFF_FFFF (-1), sub=0 -> out_sum=59'h400_0000_0000_0009.
//   6. Reset with 3 ops in flight -> out_valid=0 immediately; after release the next output is the first new op; plus an NSEG=1 build check.

Source files
------------

// File: rtl/pipelined_custom_adder_if.sv
// Valid/ready operand and result channels of pipelined_custom_adder.
// master drives operations and consumes results; slave is the adder.
interface pipelined_custom_adder_if #(
  parameter int A_WIDTH   = 58,
  parameter int B_WIDTH   = 37,
  parameter int TAG_WIDTH = 4
);

  logic                 in_valid;
  logic                 in_ready;
  logic [A_WIDTH-1:0]   in_a;
  logic [B_WIDTH-1:0]   in_b;
  logic                 in_sub;
  logic [TAG_WIDTH-1:0] in_tag;

  logic                 out_valid;
  logic                 out_ready;
  logic [A_WIDTH:0]     out_sum;
  logic [TAG_WIDTH-1:0] out_tag;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    input  in_ready, out_valid, out_sum, out_tag
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_tag, out_ready,
    output in_ready, out_valid, out_sum, out_tag
  );

endinterface

// File: rtl/pipelined_custom_adder.sv
// Segmented carry-propagate adder/subtractor: one SEG_WIDTH carry segment per stage,
// valid/ready flow control with full back-pressure and a tag carried alongside each operation.
module pipelined_custom_adder #(
  parameter int A_WIDTH   = 58,
  parameter int B_WIDTH   = 37,
  parameter int SEG_WIDTH = 16,
  parameter bit SIGNED_B  = 1'b0,
  parameter int TAG_WIDTH = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  pipelined_custom_adder_if.slave bus
);

  localparam int NSEG = (A_WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
  localparam logic [SEG_WIDTH-1:0] SEG_ONES = '1;

  if (B_WIDTH < 1 || B_WIDTH > A_WIDTH || SEG_WIDTH < 1 || SEG_WIDTH > A_WIDTH) begin : g_bad_params
    $error("pipelined_custom_adder: illegal width parameters");
  end

  // Everything a stage hands to the next one. sum holds the bits resolved so far,
  // a/bx keep the operands so later stages can pick their own segment.
  typedef struct packed {
    logic                 valid;
    logic                 sub;
    logic                 carry;
    logic [TAG_WIDTH-1:0] tag;
    logic [A_WIDTH-1:0]   a;
    logic [A_WIDTH-1:0]   bx;
    logic [A_WIDTH-1:0]   sum;
  } stage_t;

  stage_t          in_stage;
  stage_t          up      [NSEG];
  stage_t          stage_d [NSEG];
  stage_t          stage_q [NSEG];
  logic [NSEG-1:0] valid_vec;
  logic [NSEG-1:0] ready;

  // Stage-0 source: the incoming operation with B already extended to A's width.
  always_comb begin
    in_stage       = '0;
    in_stage.valid = bus.in_valid;
    in_stage.sub   = bus.in_sub;
    in_stage.carry = bus.in_sub;
    in_stage.tag   = bus.in_tag;
    in_stage.a     = bus.in_a;
    in_stage.bx    = SIGNED_B ? A_WIDTH'($signed(bus.in_b)) : A_WIDTH'(bus.in_b);
  end

  always_comb begin
    up[0] = in_stage;
    for (int k = 1; k < NSEG; k++) begin
      up[k] = stage_q[k-1];
    end
  end

  // A stage can load when it is empty or everything downstream of it can move.
  always_comb begin : ready_chain
    logic acc;
    acc       = bus.out_ready;
    valid_vec = '0;
    ready     = '0;
    for (int k = NSEG - 1; k >= 0; k--) begin
      valid_vec[k] = stage_q[k].valid;
      acc          = ~stage_q[k].valid | acc;
      ready[k]     = acc;
    end
  end

  assign bus.in_ready = rst_n & ready[0];

  always_comb begin : seg_add
    logic [SEG_WIDTH-1:0] a_seg;
    logic [SEG_WIDTH-1:0] b_seg;
    logic [SEG_WIDTH-1:0] seg_mask;
    logic [SEG_WIDTH:0]   seg_sum;
    logic [SEG_WIDTH:0]   carry_bits;
    int                   lo;
    int                   w;
    for (int k = 0; k < NSEG; k++) begin
      lo = k * SEG_WIDTH;
      // The last segment is narrower when SEG_WIDTH does not divide A_WIDTH.
      w  = (A_WIDTH - lo < SEG_WIDTH) ? (A_WIDTH - lo) : SEG_WIDTH;
      seg_mask = ~(SEG_ONES << w);
      a_seg    = SEG_WIDTH'(up[k].a >> lo) & seg_mask;
      b_seg    = SEG_WIDTH'(up[k].bx >> lo);
      if (up[k].sub) begin
        b_seg = ~b_seg;
      end
      b_seg      = b_seg & seg_mask;
      seg_sum    = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_WIDTH{1'b0}}, up[k].carry};
      carry_bits = seg_sum >> w;

      // NOTE: default every stage to "hold" before the conditional updates so no path
      // leaves stage_d unassigned and no latch is inferred.
      stage_d[k] = stage_q[k];
      if (ready[k]) begin
        stage_d[k].valid = up[k].valid;
        if (up[k].valid) begin
          stage_d[k]       = up[k];
          stage_d[k].sum   = up[k].sum | (A_WIDTH'(seg_sum[SEG_WIDTH-1:0] & seg_mask) << lo);
          stage_d[k].carry = carry_bits[0];
        end
      end
    end
  end

  // NOTE: the whole pipeline, datapath included, is cleared on reset so out_sum/out_tag
  // read as zero and nothing in flight survives; state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NSEG; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NSEG; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  assign bus.out_valid = stage_q[NSEG-1].valid;
  assign bus.out_sum   = {stage_q[NSEG-1].carry, stage_q[NSEG-1].sum};
  assign bus.out_tag   = stage_q[NSEG-1].tag;

endmodule
